mem_port_arbiter: RTL

- Shares the single unified instruction/data memory of the multi-cycle MIPS core between two requesters:
  - the CPU (multi-cycle controller/datapath);
  - a debug/program-loader port.
- Sequences each access through a small FSM with a configurable memory read latency.
- Arbitrates round-robin, with an optional debug lock that freezes the CPU.
- Exports a stall signal that the controller uses to hold pcen/irwrite/regwrite while its access is pending.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory between the CPU and a debug/loader port.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP, with a one-cycle done pulse to the winner.
module mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   input  logic          dbg_lock,
   output logic          dbg_gnt,
   output logic          dbg_done,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d;     // 1 = debug port owns the current access
   logic          last_q, last_d;       // 1 = debug port was served last
   logic          we_q, we_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          cpu_gnt_q, cpu_gnt_d;
   logic          dbg_gnt_q, dbg_gnt_d;
   logic          cpu_done_q, cpu_done_d;
   logic          dbg_done_q, dbg_done_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

   logic cpu_elig, dbg_elig, pick_dbg;

   assign cpu_elig = cpu_req & ~dbg_lock;
   assign dbg_elig = dbg_req;
   // Debug wins when alone, or when both compete and the CPU was served last.
   assign pick_dbg = dbg_elig & (~cpu_elig | ~last_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_gnt_q   <= 1'b0;
         dbg_gnt_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
         dbg_done_q  <= 1'b0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         we_q        <= we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_gnt_q   <= cpu_gnt_d;
         dbg_gnt_q   <= dbg_gnt_d;
         cpu_done_q  <= cpu_done_d;
         dbg_done_q  <= dbg_done_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      last_d      = last_q;
      we_d        = we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_gnt_d   = cpu_gnt_q;
      dbg_gnt_d   = dbg_gnt_q;
      cpu_done_d  = 1'b0;
      dbg_done_d  = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_elig | dbg_elig) begin
               state_d     = ACCESS;
               cnt_d       = 4'd0;
               owner_d     = pick_dbg;
               we_d        = pick_dbg ? dbg_we : cpu_we;
               mem_en_d    = 1'b1;
               mem_we_d    = pick_dbg ? dbg_we : cpu_we;
               mem_addr_d  = pick_dbg ? dbg_addr : cpu_addr;
               mem_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
               cpu_gnt_d   = ~pick_dbg;
               dbg_gnt_d   = pick_dbg;
            end
         end
         ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d    = RESP;
               cpu_done_d = ~owner_q;
               dbg_done_d = owner_q;
               if (!we_q) begin
                  if (owner_q) dbg_rdata_d = mem_rdata;
                  else         cpu_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            state_d   = IDLE;
            cnt_d     = 4'd0;
            last_d    = owner_q;
            cpu_gnt_d = 1'b0;
            dbg_gnt_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_gnt   = cpu_gnt_q;
   assign dbg_gnt   = dbg_gnt_q;
   assign cpu_done  = cpu_done_q;
   assign dbg_done  = dbg_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule
